mm_systolic_ctrl: RTL and testbench

Sequencer for the 8x8 output-stationary systolic matrix-multiply array. It reads K row/column bar pairs from the operand buffers and streams them into the array with `bar_valid`. It waits for the skewed wavefront to drain, then presents the 8x8 result with a valid/ready handshake and pulses `flush` to clear the PE accumulators for the next tile. It sits between the linear-layer tile scheduler (start/done) and the array plus its operand buffers.

---
 rtl/mm_systolic_ctrl.sv | 129 ++++++++++++
 tb/tb_mm_systolic_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_systolic_ctrl.sv
// Sequencer for the 8x8 output-stationary systolic array: feeds K bar pairs, drains, hands off the result, flushes.
// Optional MM_CTRL_STALL_EN adds a stall input that pauses operand reads in FEED.
module mm_systolic_ctrl #(
  parameter int AW    = 6,
  parameter int DRAIN = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW:0]   k_len,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [63:0]   row_rdata,
  input  logic [63:0]   col_rdata,
  output logic [63:0]   row_bar,
  output logic [63:0]   col_bar,
  output logic          bar_valid,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          flush,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
`ifdef MM_CTRL_STALL_EN
  ,
  input  logic          stall
`endif
);

  // Result handshake: res_valid stays high until the cycle res_ready is seen high;
  // that cycle is the transfer and the FSM moves to FLUSH on the next edge.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_DRAIN = 3'd2,
    S_OUT   = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  localparam int DW = $clog2(DRAIN + 1);

  state_t        state_q, state_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   klen_q, klen_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          bar_valid_q, bar_valid_d;
  logic          zdone_q, zdone_d;
  logic          stall_w;

`ifdef MM_CTRL_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    dcnt_d  = dcnt_q;
    zdone_d = 1'b0;
    rd_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            klen_d  = k_len;
            cnt_d   = '0;
            state_d = S_FEED;
          end else begin
            zdone_d = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (!stall_w) begin
          rd_en = 1'b1;
          // Hold the counter on the last read so rd_addr never wraps.
          if (cnt_q == klen_q - (AW+1)'(1)) begin
            dcnt_d  = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + (AW+1)'(1);
          end
        end
      end
      S_DRAIN: begin
        if (dcnt_q == DW'(DRAIN - 1)) state_d = S_OUT;
        else                          dcnt_d  = dcnt_q + DW'(1);
      end
      S_OUT: begin
        if (res_ready) state_d = S_FLUSH;
      end
      S_FLUSH: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bar_valid_d = rd_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      klen_q      <= '0;
      dcnt_q      <= '0;
      bar_valid_q <= 1'b0;
      zdone_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      klen_q      <= klen_d;
      dcnt_q      <= dcnt_d;
      bar_valid_q <= bar_valid_d;
      zdone_q     <= zdone_d;
    end
  end

  assign rd_addr   = cnt_q[AW-1:0];
  assign row_bar   = row_rdata;
  assign col_bar   = col_rdata;
  assign bar_valid = bar_valid_q;
  assign res_valid = (state_q == S_OUT);
  assign flush     = (state_q == S_FLUSH);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_FLUSH) | zdone_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mm_systolic_ctrl.sv
// Directed bench for mm_systolic_ctrl: operand buffer model, bar accumulator and cycle-stamped tile checks.
module tb_mm_systolic_ctrl;
  localparam int AW    = 6;
  localparam int DRAIN = 16;

  logic          clk = 1'b0;
  logic          rst, start, res_ready, stall;
  logic [AW:0]   k_len;
  logic          rd_en, bar_valid, res_valid, flush, busy, done;
  logic [AW-1:0] rd_addr;
  logic [63:0]   row_rdata, col_rdata, row_bar, col_bar;
  logic [2:0]    dbg_state;

  mm_systolic_ctrl #(.AW(AW), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .row_rdata(row_rdata), .col_rdata(col_rdata),
    .row_bar(row_bar), .col_bar(col_bar), .bar_valid(bar_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .flush(flush), .busy(busy), .done(done), .dbg_state(dbg_state)
`ifdef MM_CTRL_STALL_EN
    ,
    .stall(stall)
`endif
  );

  // clock / cycle stamp / operand buffers
  int cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] row_mem [64];
  logic [63:0] col_mem [64];
  always @(posedge clk) begin
    if (rd_en) begin
      row_rdata <= row_mem[rd_addr];
      col_rdata <= col_mem[rd_addr];
    end
  end

  // scoreboard
  logic [AW-1:0] exp_q [$];
  int n_chk = 0;
  int n_fail = 0;
  int acc  [8][8];
  int gold [8][8];

  task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void golden(input int k);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        gold[i][j] = 0;
        acc[i][j]  = 0;
        for (int t = 0; t < k; t++) begin
          int a, b;
          a = int'($signed(row_mem[t][i*8 +: 8]));
          b = int'($signed(col_mem[t][j*8 +: 8]));
          gold[i][j] += a * b;
        end
      end
  endfunction

  function automatic void accumulate();
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        int a, b;
        a = int'($signed(row_bar[i*8 +: 8]));
        b = int'($signed(col_bar[j*8 +: 8]));
        acc[i][j] += a * b;
      end
  endfunction

  // driver: runs one tile and checks its cycle-level behaviour
  task automatic tile(input string nm, input int k, input int rdy_dly,
                      input int st_after, input int st_len, input int ign_at);
    int s, c, rd_n, bv_n, rv_cnt, rv_rise, fl_n, fl_c, dn_n, dn_c;
    int first_rd, first_bv, st_used, post, addr_bad, hold_bad, mat_bad;
    rd_n = 0; bv_n = 0; rv_cnt = 0; rv_rise = -1; fl_n = 0; fl_c = -1;
    dn_n = 0; dn_c = -1; first_rd = -1; first_bv = -1; st_used = 0;
    post = -1; addr_bad = 0; hold_bad = 0; mat_bad = 0;
    exp_q.delete();
    for (int t = 0; t < k; t++) exp_q.push_back(AW'(t));
    golden(k);
    @(negedge clk);
    start = 1'b1; k_len = (AW+1)'(k); s = cyc;
    res_ready = (rdy_dly == 0); stall = 1'b0;
    for (int i = 0; i < 400 && post != 0; i++) begin
      @(negedge clk);
      c = cyc;
      start = (ign_at > 0 && c == s + ign_at);
      stall = (st_len > 0 && rd_n == st_after && st_used < st_len);
      if (stall) st_used++;
      if (rv_cnt >= rdy_dly) res_ready = 1'b1;
      #1;
      if (rd_en) begin
        if (exp_q.size() == 0) addr_bad++;
        else if (rd_addr !== exp_q.pop_front()) addr_bad++;
        if (rd_n == 0) first_rd = c;
        rd_n++;
      end
      if (stall && rd_addr !== AW'(st_after)) hold_bad++;
      if (bar_valid) begin
        if (bv_n == 0) first_bv = c;
        bv_n++;
        accumulate();
      end
      if (res_valid) begin
        if (rv_cnt == 0) rv_rise = c;
        rv_cnt++;
      end
      if (flush) begin fl_n++; fl_c = c; end
      if (done) begin
        dn_n++; dn_c = c;
        if (post < 0) post = 4;
      end
      if (post > 0) post--;
    end
    start = 1'b0; stall = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (acc[i][j] != gold[i][j]) mat_bad++;
    chk({nm, " timeout"}, post, 0);
    chk({nm, " first_rd"}, first_rd, s + 1);
    chk({nm, " first_bv"}, first_bv, s + 2);
    chk({nm, " rd_cnt"}, rd_n, k);
    chk({nm, " bv_cnt"}, bv_n, k);
    chk({nm, " addr_seq"}, addr_bad, 0);
    chk({nm, " addr_left"}, exp_q.size(), 0);
    chk({nm, " rv_rise"}, rv_rise, s + k + st_len + DRAIN + 1);
    chk({nm, " rv_len"}, rv_cnt, rdy_dly + 1);
    chk({nm, " flush_cnt"}, fl_n, 1);
    chk({nm, " done_cnt"}, dn_n, 1);
    chk({nm, " flush_cyc"}, fl_c, rv_rise + rdy_dly + 1);
    chk({nm, " done_cyc"}, dn_c, rv_rise + rdy_dly + 1);
    chk({nm, " matrix"}, mat_bad, 0);
    chk({nm, " busy_end"}, busy, 0);
    if (st_len > 0) chk({nm, " stall_hold"}, hold_bad, 0);
  endtask

  initial begin
    int s, c, rd_n, dn_n, dn_c, fl_n, rv_n;
    rst = 1'b1; start = 1'b0; k_len = '0; res_ready = 1'b0; stall = 1'b0;
    for (int t = 0; t < 64; t++) begin
      row_mem[t] = {$urandom, $urandom};
      col_mem[t] = {$urandom, $urandom};
    end
    repeat (2) @(negedge clk);
    chk("rst rd_en", rd_en, 0);
    chk("rst bar_valid", bar_valid, 0);
    chk("rst res_valid", res_valid, 0);
    chk("rst flush", flush, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst rd_addr", rd_addr, 0);
    rst = 1'b0;

    // k=1, ones x twos: every element is 1*2
    row_mem[0] = {8{8'h01}};
    col_mem[0] = {8{8'h02}};
    tile("k1", 1, 0, 0, 0, 0);
    chk("k1 acc00", acc[0][0], 2);
    chk("k1 acc77", acc[7][7], 2);

    for (int t = 0; t < 64; t++) begin
      row_mem[t] = {$urandom, $urandom};
      col_mem[t] = {$urandom, $urandom};
    end
    tile("k8", 8, 0, 0, 0, 0);
    tile("rdy5", 2, 5, 0, 0, 0);
    tile("ign", 3, 0, 0, 0, 8);
    tile("kmax", 64, 1, 0, 0, 0);

    // k_len = 0: done next cycle, nothing else
    @(negedge clk);
    start = 1'b1; k_len = '0; s = cyc;
    rd_n = 0; dn_n = 0; dn_c = -1; fl_n = 0; rv_n = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = 1'b0; c = cyc;
      #1;
      if (rd_en) rd_n++;
      if (done) begin dn_n++; dn_c = c; end
      if (flush) fl_n++;
      if (res_valid) rv_n++;
    end
    chk("k0 done_cyc", dn_c, s + 1);
    chk("k0 done_cnt", dn_n, 1);
    chk("k0 rd_cnt", rd_n, 0);
    chk("k0 flush", fl_n, 0);
    chk("k0 res_valid", rv_n, 0);

    // reset on the third FEED cycle of a k=8 tile
    @(negedge clk);
    start = 1'b1; k_len = (AW+1)'(8); s = cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("mid rd_en_pre", rd_en, 1);
    chk("mid rd_addr_pre", rd_addr, 2);
    rst = 1'b1;
    #1;
    chk("mid rd_en", rd_en, 0);
    chk("mid bar_valid", bar_valid, 0);
    chk("mid busy", busy, 0);
    chk("mid rd_addr", rd_addr, 0);
    chk("mid done", done, 0);
    chk("mid flush", flush, 0);
    @(negedge clk);
    rst = 1'b0;
    dn_n = 0; fl_n = 0; rd_n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      #1;
      if (done) dn_n++;
      if (flush) fl_n++;
      if (rd_en) rd_n++;
    end
    chk("mid post_done", dn_n, 0);
    chk("mid post_flush", fl_n, 0);
    chk("mid post_rd", rd_n, 0);
    tile("after_rst", 8, 0, 0, 0, 0);

`ifdef MM_CTRL_STALL_EN
    tile("stall", 4, 0, 2, 2, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
